// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the memory controller
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } imarb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, with wrap
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    logic [W-1:0] cand;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/icache_mem_arbiter.sv
// rtl/icache_mem_arbiter.sv - round-robin icache refill responder on the shared RAM port
module icache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CPUS-1:0]       iREN,
    input  word_t [CPUS-1:0]      iaddr,
    output logic [CPUS-1:0]       iwait,
    output word_t [CPUS-1:0]      iload,
    input  logic                  dbusy,
    output logic                  ramREN,
    output word_t                 ramaddr,
    input  word_t                 ramload,
    input  ramstate_t             ramstate
);

    localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    imarb_state_t       state, state_d;
    logic [GW-1:0]      rr_ptr, grant, gnt_idx;
    logic               gnt_valid;
    word_t              addr_q;
    logic [TW-1:0]      tcnt;
    logic [CPUS-1:0]    iwait_q, iwait_d;
    word_t [CPUS-1:0]   iload_q;
    logic               ramren_q, ramren_d;

    rr_arbiter #(.N(CPUS)) u_rr (
        .req       (iREN),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            addr_q   <= '0;
            tcnt     <= '0;
            iwait_q  <= '1;
            iload_q  <= '0;
            ramren_q <= 1'b0;
        end else begin
            state    <= state_d;
            iwait_q  <= iwait_d;
            ramren_q <= ramren_d;
            case (state)
                IDLE: begin
                    if (state_d == REQ) begin
                        grant  <= gnt_idx;
                        addr_q <= iaddr[gnt_idx] & ~32'h3;
                        tcnt   <= '0;
                    end
                end
                REQ: begin
                    if (state_d == RESP) begin
                        iload_q[grant] <= ramload;
                    end else if (state_d == REQ && tcnt != TW'(TIMEOUT)) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == GW'(CPUS - 1)) ? '0 : grant + GW'(1);
                end
                default: ;
            endcase
        end
    end

    // An abandoned request (pc reset, RAM error, timeout) leaves rr_ptr alone so the port can win again.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!dbusy && gnt_valid) state_d = REQ;
            end
            REQ: begin
                if (!iREN[grant])                                  state_d = IDLE;
                else if (ramstate == ACCESS)                       state_d = RESP;
                else if (ramstate == ERROR || tcnt == TW'(TIMEOUT)) state_d = IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, so every port is driven straight from a flop.
    always_comb begin
        ramren_d = (state_d == REQ);
        iwait_d  = '1;
        if (state_d == RESP) iwait_d[grant] = 1'b0;
    end

    assign ramREN  = ramren_q;
    assign ramaddr = addr_q;
    assign iwait   = iwait_q;
    assign iload   = iload_q;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// tb/tb_icache_mem_arbiter.sv - self-checking bench for icache_mem_arbiter
module tb_icache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS    = 2;
    localparam int TIMEOUT = 15;

    logic              CLK = 1'b0;
    logic              RST;
    logic [CPUS-1:0]   iREN;
    word_t [CPUS-1:0]  iaddr;
    logic [CPUS-1:0]   iwait;
    word_t [CPUS-1:0]  iload;
    logic              dbusy;
    logic              ramREN;
    word_t             ramaddr;
    word_t             ramload;
    ramstate_t         ramstate;

    always #5 CLK = ~CLK;

    icache_mem_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dbusy    (dbusy),
        .ramREN   (ramREN),
        .ramaddr  (ramaddr),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    int    total = 0;
    int    bad   = 0;

    // Transaction-level reference: which port has a read outstanding, how long it has waited,
    // which port is being answered this cycle, and who is first in line next time.
    int    owner      = -1;
    int    waited     = 0;
    bit    responding = 1'b0;
    int    resp_port  = 0;
    int    next_first = 0;
    word_t exp_addr   = '0;
    word_t exp_load [CPUS];
    int    grants [$];

    function automatic int pick();
        for (int i = 0; i < CPUS; i++) begin
            int p = (next_first + i) % CPUS;
            if (iREN[p]) return p;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            owner = -1; responding = 1'b0; next_first = 0; exp_addr = '0;
            for (int p = 0; p < CPUS; p++) exp_load[p] = '0;
        end else if (responding) begin
            responding = 1'b0;
            next_first = (resp_port + 1) % CPUS;
        end else if (owner >= 0) begin
            if (!iREN[owner]) owner = -1;
            else if (ramstate == ACCESS) begin
                exp_load[owner] = ramload;
                responding = 1'b1;
                resp_port  = owner;
                owner      = -1;
            end else if (ramstate == ERROR || waited == TIMEOUT) owner = -1;
            else waited++;
        end else if (!dbusy && iREN != '0) begin
            owner    = pick();
            exp_addr = iaddr[owner] & ~32'h3;
            waited   = 0;
        end
    endtask

    task automatic check_outputs();
        logic [CPUS-1:0] exp_iwait;
        exp_iwait = '1;
        if (responding) exp_iwait[resp_port] = 1'b0;
        chk("ramREN", 32'(ramREN), 32'(owner >= 0));
        chk("ramaddr", ramaddr, exp_addr);
        chk("iwait", 32'(iwait), 32'(exp_iwait));
        for (int p = 0; p < CPUS; p++) chk($sformatf("iload%0d", p), iload[p], exp_load[p]);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        for (int p = 0; p < CPUS; p++) if (iwait[p] === 1'b0) grants.push_back(p);
    endtask

    // RAM that answers BUSY for 'lat' REQ cycles then ACCESS; cnt counts cycles with ramREN seen.
    task automatic ram_drive(input int lat, inout int cnt);
        if (ramREN) begin
            ramstate = (cnt >= lat) ? ACCESS : BUSY;
            ramload  = $urandom;
            cnt++;
        end else begin
            ramstate = FREE;
            cnt = 0;
        end
    endtask

    initial begin
        int cnt;
        RST = 1'b1; iREN = '0; iaddr = '0; dbusy = 1'b0; ramload = '0; ramstate = FREE;
        step(); step();
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_ramREN", 32'(ramREN), 32'h0);

        // Single request, immediate ACCESS
        RST = 1'b0; iREN = 2'b01; iaddr[0] = 32'h104; iaddr[1] = 32'h777;
        step();
        chk("t1_ramaddr", ramaddr, 32'h104);
        chk("t1_ramREN", 32'(ramREN), 32'h1);
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        step();
        chk("t1_pulse", 32'(iwait), 32'h2);
        iREN = '0; ramstate = FREE;
        step(); step();
        chk("t1_iwait_after", 32'(iwait), 32'h3);
        chk("t1_iload_held", iload[0], 32'hDEADBEEF);

        // Both ports requesting continuously, RAM latency 2 BUSY then ACCESS
        RST = 1'b1; step(); RST = 1'b0;
        grants.delete(); cnt = 0; iREN = 2'b11;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            iaddr[0] = $urandom; iaddr[1] = $urandom;
            ram_drive(2, cnt);
            step();
        end
        chk("t2_count", 32'(grants.size()), 32'd4);
        if (grants.size() == 4)
            for (int k = 0; k < 4; k++) chk($sformatf("t2_grant%0d", k), 32'(grants[k]), 32'(k % 2));
        iREN = '0; ramstate = FREE; step(); step();

        // dbusy holds off new grants
        dbusy = 1'b1; iREN = 2'b01; iaddr[0] = 32'h40;
        for (int c = 0; c < 4; c++) step();
        chk("t3_blocked", 32'(ramREN), 32'h0);
        dbusy = 1'b0;
        step();
        chk("t3_granted", 32'(ramREN), 32'h1);
        dbusy = 1'b1; ramstate = ACCESS; ramload = 32'h12345678;
        step();
        chk("t3_no_preempt", 32'(iwait), 32'h2);
        dbusy = 1'b0; iREN = '0; ramstate = FREE; step(); step();

        // Timeout: BUSY for 20 cycles, then ACCESS
        grants.delete(); iREN = 2'b01; iaddr[0] = 32'h80; ramstate = BUSY;
        for (int c = 0; c < 20; c++) step();
        chk("t4_no_pulse", 32'(grants.size()), 32'h0);
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) step();
        chk("t4_one_pulse", 32'(grants.size()), 32'h1);
        iREN = '0; ramstate = FREE; step(); step();

        // pc reset drops iREN in the 3rd REQ cycle
        grants.delete(); iREN = 2'b01; iaddr[0] = 32'h200; ramstate = BUSY;
        step(); step(); step();
        iREN = 2'b00;
        step();
        chk("t5_abort", 32'(ramREN), 32'h0);
        ramstate = ACCESS;
        for (int c = 0; c < 3; c++) step();
        chk("t5_no_pulse", 32'(grants.size()), 32'h0);
        ramstate = FREE; step();

        // ERROR then retry, then reset mid-REQ
        grants.delete(); iREN = 2'b10; iaddr[1] = 32'h303;
        step();
        ramstate = ERROR; step();
        ramstate = ACCESS; ramload = 32'hA5A5A5A5;
        for (int c = 0; c < 4; c++) step();
        chk("t6_one_pulse", 32'(grants.size()), 32'h1);
        chk("t6_data", iload[1], 32'hA5A5A5A5);
        ramstate = BUSY; step(); step();
        RST = 1'b1; step();
        chk("t6_rst_ramREN", 32'(ramREN), 32'h0);
        chk("t6_rst_iload", iload[1], 32'h0);
        RST = 1'b0; iREN = '0; ramstate = FREE; step();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < CPUS; p++) begin
                if (iwait[p] === 1'b0 && $urandom_range(0, 1) == 1) iREN[p] = 1'b0;
                else if ($urandom_range(0, 7) == 0) iREN[p] = ~iREN[p];
                if ($urandom_range(0, 3) == 0) iaddr[p] = $urandom;
            end
            dbusy    = ($urandom_range(0, 3) == 0);
            ramstate = ramstate_t'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) ramstate = BUSY;
            ramload  = $urandom;
            RST      = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
